// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline skid register.
package pipe_pkg;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } skid_state_e;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

endpackage

// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline skid buffer (head + skid register) with registered up_ready_o.
// Optional stall counter output stall_cnt_o is enabled by defining PIPE_SKID_STATS_EN.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned   IW        = 32,
  parameter int unsigned   PW        = 96,
  parameter logic [IW-1:0] NOP_INSTR = IW'(NOP_INSTR_DEFAULT)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          up_valid_i,
  output logic          up_ready_o,
  input  logic [IW-1:0] instr_i,
  input  logic [PW-1:0] payload_i,
  output logic          down_valid_o,
  input  logic          down_ready_i,
  output logic [IW-1:0] instr_o,
  output logic [PW-1:0] payload_o,
  output logic [1:0]    occ_o
`ifdef PIPE_SKID_STATS_EN
  ,
  output logic [31:0]   stall_cnt_o
`endif
);

  skid_state_e   r_state;
  skid_state_e   w_state_nxt;
  logic          r_up_ready;
  logic [IW-1:0] r_head_instr;
  logic [PW-1:0] r_head_payload;
  logic [IW-1:0] r_skid_instr;
  logic [PW-1:0] r_skid_payload;

  logic w_down_valid;
  logic w_push;
  logic w_pop;
  logic w_load_head;
  logic w_load_skid;
  logic w_skid_to_head;

  assign w_down_valid = (r_state != StEmpty);
  assign w_push       = up_valid_i & r_up_ready;
  assign w_pop        = w_down_valid & down_ready_i;

  always_comb begin
    w_state_nxt    = r_state;
    w_load_head    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_head = 1'b0;
    if (flush_i) begin
      w_state_nxt = StEmpty;
    end else begin
      unique case (r_state)
        StEmpty: begin
          if (w_push) begin
            w_state_nxt = StOne;
            w_load_head = 1'b1;
          end
        end
        StOne: begin
          unique case ({w_push, w_pop})
            2'b10: begin
              w_state_nxt = StFull;
              w_load_skid = 1'b1;
            end
            2'b01:   w_state_nxt = StEmpty;
            2'b11:   w_load_head = 1'b1;
            default: w_state_nxt = StOne;
          endcase
        end
        StFull: begin
          if (w_pop) begin
            w_state_nxt    = StOne;
            w_skid_to_head = 1'b1;
          end
        end
        default: w_state_nxt = StEmpty;
      endcase
    end
  end

  // Ready is a registered copy of "next state is not FULL" so it has no comb path.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state        <= StEmpty;
      r_up_ready     <= 1'b1;
      r_head_instr   <= '0;
      r_head_payload <= '0;
      r_skid_instr   <= '0;
      r_skid_payload <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_up_ready <= (w_state_nxt != StFull);
      if (w_load_head) begin
        r_head_instr   <= instr_i;
        r_head_payload <= payload_i;
      end else if (w_skid_to_head) begin
        r_head_instr   <= r_skid_instr;
        r_head_payload <= r_skid_payload;
      end
      if (w_load_skid) begin
        r_skid_instr   <= instr_i;
        r_skid_payload <= payload_i;
      end
    end
  end

  assign up_ready_o   = r_up_ready;
  assign down_valid_o = w_down_valid;
  assign instr_o      = w_down_valid ? r_head_instr : NOP_INSTR;
  assign payload_o    = w_down_valid ? r_head_payload : '0;
  assign occ_o        = 2'(r_state);

`ifdef PIPE_SKID_STATS_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_stall_cnt <= '0;
    end else if (w_down_valid && !down_ready_i && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: queue-based reference model plus directed literal checks.
module tb_pipe_skid_reg;

  localparam int unsigned IW = 32;
  localparam int unsigned PW = 96;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          up_valid;
  logic          up_ready;
  logic [IW-1:0] instr;
  logic [PW-1:0] pl;
  logic          down_valid;
  logic          dr;
  logic [IW-1:0] instr_out;
  logic [PW-1:0] pl_out;
  logic [1:0]    occ;
`ifdef PIPE_SKID_STATS_EN
  logic [31:0]   stall_cnt;
`endif

  pipe_skid_reg #(
    .IW(IW),
    .PW(PW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .up_valid_i  (up_valid),
    .up_ready_o  (up_ready),
    .instr_i     (instr),
    .payload_i   (pl),
    .down_valid_o(down_valid),
    .down_ready_i(dr),
    .instr_o     (instr_out),
    .payload_o   (pl_out),
    .occ_o       (occ)
`ifdef PIPE_SKID_STATS_EN
    ,
    .stall_cnt_o (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] instr;
    logic [PW-1:0] pl;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_stall = '0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic        chk_en = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a queue of at most two entries, updated on each rising edge.
  initial begin
    bit   push;
    bit   pop;
    ent_t e;
    forever begin
      @(posedge clk);
      if (rst || flush) begin
        q.delete();
        m_stall = '0;
      end else begin
        push = up_valid && (q.size() < 2);
        pop  = (q.size() > 0) && dr;
        if (q.size() > 0 && !dr && m_stall != 32'hffff_ffff) m_stall = m_stall + 1;
        if (pop) void'(q.pop_front());
        if (push) begin
          e.instr = instr;
          e.pl    = pl;
          q.push_back(e);
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("m_ready", up_ready, q.size() < 2);
        chk("m_valid", down_valid, q.size() > 0);
        chk("m_occ", occ, q.size());
        chk("m_instr", instr_out, (q.size() > 0) ? q[0].instr : NOP);
        chk("m_payload", pl_out, (q.size() > 0) ? q[0].pl : '0);
`ifdef PIPE_SKID_STATS_EN
        chk("m_stall", stall_cnt, m_stall);
`endif
      end
    end
  end

  task automatic fill_ab(input logic [31:0] a, input logic [31:0] b);
    dr       = 1'b0;
    up_valid = 1'b1;
    instr    = a;
    pl       = 96'(a);
    tick();
    instr    = b;
    pl       = 96'(b);
    tick();
    up_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; up_valid = 1'b0; dr = 1'b0; instr = '0; pl = '0;
    tick();
    tick();
    rst    = 1'b0;
    chk_en = 1'b1;
    chk("rst_ready", up_ready, 1'b1);
    chk("rst_valid", down_valid, 1'b0);
    chk("rst_instr", instr_out, NOP);
    chk("rst_payload", pl_out, '0);
    chk("rst_occ", occ, 2'd0);

    // Basic flow
    up_valid = 1'b1; instr = 32'h0050_0093; pl = 96'h1; dr = 1'b1;
    tick();
    up_valid = 1'b0;
    chk("basic_valid", down_valid, 1'b1);
    chk("basic_instr", instr_out, 32'h0050_0093);
    chk("basic_payload", pl_out, 96'h1);
    chk("basic_occ", occ, 2'd1);
    tick();
    chk("basic_drain", occ, 2'd0);

    // Fill and backpressure
    fill_ab(32'hA, 32'hB);
    chk("full_occ", occ, 2'd2);
    chk("full_ready", up_ready, 1'b0);
    up_valid = 1'b1; instr = 32'hC; pl = 96'hC;
    tick();
    tick();
    chk("full_hold_occ", occ, 2'd2);
    chk("full_hold_instr", instr_out, 32'hA);
    dr = 1'b1;
    tick();
    chk("drain_b", instr_out, 32'hB);
    tick();
    chk("drain_c", instr_out, 32'hC);
    up_valid = 1'b0;
    tick();
    chk("drain_empty", occ, 2'd0);

    // Simultaneous push and pop in ONE
    dr = 1'b0; up_valid = 1'b1; instr = 32'h100; pl = 96'h100;
    tick();
    dr = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      instr = 32'h100 + 32'(i);
      pl    = 96'(i);
      tick();
      chk("stream_occ", occ, 2'd1);
      chk("stream_instr", instr_out, 32'h100 + 32'(i));
    end
    up_valid = 1'b0;
    tick();

    // Flush while full with a same-cycle offer
    fill_ab(32'h11, 32'h22);
    flush = 1'b1; up_valid = 1'b1; instr = 32'hDEAD; pl = 96'hDEAD;
    tick();
    flush = 1'b0; up_valid = 1'b0; dr = 1'b1;
    chk("flush_occ", occ, 2'd0);
    chk("flush_instr", instr_out, NOP);
    chk("flush_ready", up_ready, 1'b1);
    tick();
    chk("flush_no_ghost", down_valid, 1'b0);

    // Reset while full
    fill_ab(32'h33, 32'h44);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_ready", up_ready, 1'b1);
    chk("rst2_valid", down_valid, 1'b0);
    chk("rst2_instr", instr_out, NOP);
    chk("rst2_payload", pl_out, '0);
    chk("rst2_occ", occ, 2'd0);

`ifdef PIPE_SKID_STATS_EN
    chk("rst2_stall", stall_cnt, 32'd0);
    dr = 1'b0; up_valid = 1'b1; instr = 32'h55; pl = 96'h55;
    tick();
    up_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("stall_7", stall_cnt, 32'd7);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("stall_flush", stall_cnt, 32'd0);
`endif

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      up_valid = ($urandom % 4) != 0;
      dr       = ($urandom % 3) != 0;
      flush    = ($urandom % 40) == 0;
      rst      = ($urandom % 150) == 0;
      instr    = $urandom;
      pl       = {$urandom, $urandom, $urandom};
      tick();
    end
    rst = 1'b0; flush = 1'b0; up_valid = 1'b0; dr = 1'b1;
    tick();
    tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
